// File: rtl/round_sequencer.sv
// Memory-game round controller: LFSR pattern generation, LED
// playback, serial input collection and pass/fail scoring.
module round_sequencer #(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 4,
  parameter int          GAP_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       btn_valid,
  input  logic       btn_bit,
  output logic       busy,
  output logic       led_on,
  output logic       led_bit,
  output logic       collecting,
  output logic       round_pass,
  output logic       round_fail,
  output logic       game_over,
  output logic [4:0] level
);

  localparam int T1 =
    (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX =
    (TIMEOUT_CYCLES > T1) ? TIMEOUT_CYCLES : T1;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, GEN, SHOW_ON, SHOW_GAP,
    COLLECT, CHECK, PASS, FAIL
  } state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr, lfsr_nx;
  logic [15:0]   pattern, guess, mask;
  logic [4:0]    received;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic          show_done, gap_done, time_out;
  logic          all_in, match, last_lvl;
  logic          do_start, do_gen, do_step;
  logic          do_open, do_take, do_next;

  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400)
                           : (lfsr >> 1);

  assign show_done = timer == TW'(SHOW_CYCLES - 1);
  assign gap_done  = timer == TW'(GAP_CYCLES - 1);
  assign time_out  = !btn_valid &&
                     timer == TW'(TIMEOUT_CYCLES - 1);
  assign all_in    = btn_valid &&
                     (received + 5'd1 == level);
  assign mask      = 16'((32'd1 << level) - 32'd1);
  assign match     = ((guess ^ pattern) & mask) == '0;
  assign last_lvl  = level == 5'(MAX_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = GEN;
      GEN:      state_nx = SHOW_ON;
      SHOW_ON:  if (show_done) state_nx = SHOW_GAP;
      SHOW_GAP: begin
        if (gap_done)
          state_nx = (idx == 4'd0) ? COLLECT : SHOW_ON;
      end
      COLLECT: begin
        if (all_in)        state_nx = CHECK;
        else if (time_out) state_nx = FAIL;
      end
      CHECK:    state_nx = match ? PASS : FAIL;
      PASS:     state_nx = last_lvl ? IDLE : GEN;
      FAIL:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    // abort overrides every transition out of a busy state
    if (abort && state != IDLE) state_nx = IDLE;
  end

  assign do_start = state == IDLE && start;
  assign do_gen   = state == GEN;
  assign do_step  = state == SHOW_GAP &&
                    state_nx == SHOW_ON;
  assign do_open  = state == SHOW_GAP &&
                    state_nx == COLLECT;
  assign do_take  = state == COLLECT &&
                    btn_valid && !abort;
  assign do_next  = state == PASS && state_nx == GEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      pattern  <= '0;
      guess    <= '0;
      level    <= '0;
      received <= '0;
      idx      <= '0;
    end else begin
      unique case (1'b1)
        do_start: level <= 5'd1;
        do_gen: begin
          lfsr    <= lfsr_nx;
          pattern <= lfsr_nx;
          idx     <= 4'(level - 5'd1);
        end
        do_step: idx <= idx - 4'd1;
        do_open: begin
          guess    <= '0;
          received <= '0;
        end
        do_take: begin
          guess    <= {guess[14:0], btn_bit};
          received <= received + 5'd1;
        end
        do_next: level <= level + 5'd1;
        default: ;
      endcase
    end
  end

  // one timer serves show, gap and input-timeout windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else begin
      unique case (state)
        SHOW_ON, SHOW_GAP:
          timer <= (state_nx == state) ?
                   timer + TW'(1) : '0;
        COLLECT:
          timer <= (btn_valid || state_nx != COLLECT) ?
                   '0 : timer + TW'(1);
        default: timer <= '0;
      endcase
    end
  end

  assign busy       = state != IDLE;
  assign led_on     = state == SHOW_ON;
  assign led_bit    = led_on & pattern[idx];
  assign collecting = state == COLLECT;
  assign round_pass = state == PASS;
  assign round_fail = state == FAIL;
  assign game_over  = (state == FAIL) ||
                      (state == PASS && last_lvl);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: table-driven rounds, scoreboarded
// pass/fail pulses, and hand sequences for abort/timeout/reset.
module tb_round_sequencer;

  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       btn_valid = 1'b0;
  logic       btn_bit = 1'b0;
  logic       busy, led_on, led_bit, collecting;
  logic       round_pass, round_fail, game_over;
  logic [4:0] level;
  logic       busy2, led_on2, led_bit2, collecting2;
  logic       round_pass2, round_fail2, game_over2;
  logic [4:0] level2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .btn_valid(btn_valid),
    .btn_bit(btn_bit), .busy(busy), .led_on(led_on),
    .led_bit(led_bit), .collecting(collecting),
    .round_pass(round_pass), .round_fail(round_fail),
    .game_over(game_over), .level(level)
  );

  round_sequencer #(.MAX_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .btn_valid(btn_valid),
    .btn_bit(btn_bit), .busy(busy2), .led_on(led_on2),
    .led_bit(led_bit2), .collecting(collecting2),
    .round_pass(round_pass2), .round_fail(round_fail2),
    .game_over(game_over2), .level(level2)
  );

  typedef struct packed {
    logic       pass;
    logic       over;
    logic [4:0] lvl;
  } res_t;

  typedef struct {
    logic       corrupt;
    logic       exp_pass;
    logic       exp_over;
    logic [4:0] exp_level;
  } vec_t;

  res_t        sb[$];
  res_t        exp_r;
  vec_t        tbl[4];
  logic [15:0] m_lfsr;
  logic [15:0] cur_pat;
  int          n;

  task automatic chk1(string nm, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chk5(string nm, logic [4:0] a,
                      logic [4:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chki(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (round_pass || round_fail)) begin
      if (sb.size() == 0) begin
        chk1("unexpected_pass", round_pass, 1'b0);
        chk1("unexpected_fail", round_fail, 1'b0);
      end else begin
        exp_r = sb.pop_front();
        chk1("pulse_pass", round_pass, exp_r.pass);
        chk1("pulse_fail", round_fail, !exp_r.pass);
        chk1("pulse_over", game_over, exp_r.over);
        chk5("pulse_level", level, exp_r.lvl);
      end
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string nm);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_led_on"}, led_on, 1'b0);
    chk1({nm, "_led_bit"}, led_bit, 1'b0);
    chk1({nm, "_collect"}, collecting, 1'b0);
    chk1({nm, "_pass"}, round_pass, 1'b0);
    chk1({nm, "_fail"}, round_fail, 1'b0);
    chk1({nm, "_over"}, game_over, 1'b0);
    chk5({nm, "_level"}, level, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_lfsr = 16'hACE1;
    sb.delete();
    tick(2);
    chk_zero("rst");
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic start_game(logic with_abort);
    start = 1'b1;
    abort = with_abort;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk5("start_level", level, 5'd1);
    chk1("start_busy", busy, 1'b1);
  endtask

  // entered in the GEN cycle; leaves in the first COLLECT cycle
  task automatic watch_show(int lvl, logic poke);
    chk1("gen_led_on", led_on, 1'b0);
    chk1("gen_busy", busy, 1'b1);
    m_lfsr = lfsr_step(m_lfsr);
    cur_pat = m_lfsr;
    tick(1);
    for (int i = lvl - 1; i >= 0; i--) begin
      for (int c = 0; c < SHOW; c++) begin
        chk1("show_led_on", led_on, 1'b1);
        chk1("show_led_bit", led_bit, cur_pat[i]);
        if (poke && i == lvl - 1 && c == 0) begin
          btn_valid = 1'b1;
          btn_bit = 1'b1;
          start = 1'b1;
        end
        tick(1);
        btn_valid = 1'b0;
        start = 1'b0;
      end
      for (int c = 0; c < GAP; c++) begin
        chk1("gap_led_on", led_on, 1'b0);
        chk1("gap_led_bit", led_bit, 1'b0);
        tick(1);
      end
    end
    chk1("collect_open", collecting, 1'b1);
    chk5("show_level", level, 5'(lvl));
  endtask

  // leaves in the PASS/FAIL cycle
  task automatic enter_bits(int nb, logic [15:0] bits,
                            logic ep, logic eo,
                            logic [4:0] lvl);
    for (int i = nb - 1; i >= 0; i--) begin
      chk1("collecting", collecting, 1'b1);
      btn_valid = 1'b1;
      btn_bit = bits[i];
      if (i == 0) sb.push_back(res_t'{ep, eo, lvl});
      tick(1);
      btn_valid = 1'b0;
      if (i != 0) tick(2);
    end
    chk1("check_collect", collecting, 1'b0);
    chk1("check_busy", busy, 1'b1);
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 5'd2};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 5'd3};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 5'd4};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 5'd4};

    do_reset();

    // level 1 pass, then level 2 wrong input
    start_game(1'b0);
    watch_show(1, 1'b0);
    enter_bits(1, 16'h0000, 1'b1, 1'b0, 5'd1);
    tick(1);
    chk5("lvl2_level", level, 5'd2);
    watch_show(2, 1'b0);
    enter_bits(2, 16'h0002, 1'b0, 1'b1, 5'd2);
    tick(1);
    chk1("fail_idle_busy", busy, 1'b0);
    chk5("fail_keep_level", level, 5'd2);

    // timeout with an ignored strobe during the show
    start_game(1'b0);
    watch_show(1, 1'b1);
    sb.push_back(res_t'{1'b0, 1'b1, 5'd1});
    n = 0;
    while (!round_fail && n < 100) begin
      if (collecting) n++;
      tick(1);
    end
    chk1("timeout_fail", round_fail, 1'b1);
    chki("timeout_cycles", n, 32);
    tick(1);
    chk1("timeout_idle", busy, 1'b0);
    chk5("timeout_level", level, 5'd1);

    // abort in the second SHOW_ON cycle
    start_game(1'b0);
    m_lfsr = lfsr_step(m_lfsr);
    tick(1);
    chk1("abort_pre_led", led_on, 1'b1);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk1("abort_led_on", led_on, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk5("abort_level", level, 5'd1);
    tick(3);
    start_game(1'b0);
    watch_show(1, 1'b0);
    enter_bits(1, cur_pat, 1'b1, 1'b0, 5'd1);
    tick(1);
    chk5("post_abort_lvl", level, 5'd2);

    // asynchronous reset in the middle of a show
    tick(1);
    chk1("midrst_pre_led", led_on, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    m_lfsr = 16'hACE1;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // table of rounds in one game
    start_game(1'b0);
    for (int r = 0; r < 4; r++) begin
      watch_show(r + 1, r == 1);
      enter_bits(r + 1,
                 cur_pat ^ {15'd0, tbl[r].corrupt},
                 tbl[r].exp_pass, tbl[r].exp_over,
                 5'(r + 1));
      tick(1);
      chk5("tbl_level", level, tbl[r].exp_level);
      chk1("tbl_busy", busy, !tbl[r].exp_over);
    end

    // winning at MAX_LEN=2; start+abort together in IDLE
    do_reset();
    start_game(1'b1);
    chk5("win_lvl_start", level2, 5'd1);
    watch_show(1, 1'b0);
    enter_bits(1, cur_pat, 1'b1, 1'b0, 5'd1);
    chk1("win1_pass", round_pass2, 1'b1);
    chk1("win1_over", game_over2, 1'b0);
    tick(1);
    watch_show(2, 1'b0);
    enter_bits(2, cur_pat, 1'b1, 1'b0, 5'd2);
    chk1("win2_pass", round_pass2, 1'b1);
    chk1("win2_fail", round_fail2, 1'b0);
    chk1("win2_over", game_over2, 1'b1);
    chk5("win2_level", level2, 5'd2);
    tick(1);
    chk1("win_idle", busy2, 1'b0);
    chk5("win_keep_level", level2, 5'd2);
    chk1("nowin_busy", busy, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk1("final_abort", busy, 1'b0);

    tick(2);
    chki("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Top-level round controller for the memory game. Generates each round's pattern from an internal LFSR and plays it back bit-by-bit on the LED outputs with fixed on/gap timing. It then opens an input window, collects the player's bits serially, compares them against the pattern and reports pass or fail. It owns the level (score) count and replaces the ad-hoc coupling of the mode FSM, counter, comparator and input handler with one sequenced datapath.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (range 1..16); passing level MAX_LEN wins the game.
SHOW_CYCLES, 4, cycles each pattern bit is displayed (led_on=1); must be ≥1.
GAP_CYCLES, 2, cycles of led_on=0 after each displayed bit; must be ≥1.
TIMEOUT_CYCLES, 32, consecutive cycles without btn_valid in COLLECT before the round fails.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin new game; honoured only in IDLE
abort  input  1  return to IDLE from any state
btn_valid  input  1  one-cycle strobe: player entered a bit
btn_bit  input  1  player bit, qualified by btn_valid
busy  output  1  1 in every state except IDLE
led_on  output  1  pattern bit being displayed
led_bit  output  1  displayed bit value; 0 when led_on=0
collecting  output  1  input window open (COLLECT state)
round_pass  output  1  one-cycle pulse: round correct
round_fail  output  1  one-cycle pulse: wrong input or timeout
game_over  output  1  one-cycle pulse: game ended (fail, or pass at MAX_LEN)
level  output  5  current round length; holds final value after game end

Behaviour:
- Reset (async, rst_n=0): state IDLE; all 1-bit outputs 0; level=0; lfsr=LFSR_SEED; guess, bit and timer counters cleared.
- LFSR: 16-bit Galois, right shift, taps mask 16'hB400: if lfsr[0], lfsr <= (lfsr>>1)^16'hB400; else lfsr <= lfsr>>1. It advances exactly once per GEN cycle and is never reset by start.
- States: IDLE, GEN, SHOW_ON, SHOW_GAP, COLLECT, CHECK, PASS, FAIL.
- IDLE: on start, set level=1 and go to GEN.
- GEN (1 cycle): advance LFSR; the pattern register captures the new LFSR value; set idx=level-1; go to SHOW_ON.
- SHOW_ON: led_on=1, led_bit=pattern[idx], held for SHOW_CYCLES cycles; then go to SHOW_GAP.
- SHOW_GAP: led_on=0 for GAP_CYCLES cycles. Then, if idx==0, clear guess, received count and timer and go to COLLECT; otherwise idx-1 and go to SHOW_ON. Bits play MSB-first.
- Latency: start sampled at edge k gives GEN in cycle k+1 and the first led_on cycle at k+2.
- COLLECT: collecting=1. Each btn_valid cycle: guess <= {guess[14:0],btn_bit}, received+1, timer cleared. When received reaches level, go to CHECK (the final bit is captured on that edge). With no btn_valid, timer+1; timer==TIMEOUT_CYCLES goes to FAIL.
- btn_valid outside COLLECT is ignored; no state change.
- CHECK (1 cycle): compare guess[level-1:0] with pattern[level-1:0]. Equal goes to PASS, otherwise FAIL.
- PASS (1 cycle): round_pass=1. If level==MAX_LEN, also game_over=1 and go to IDLE. Otherwise level+1 and go to GEN.
- FAIL (1 cycle): round_fail=1, game_over=1; go to IDLE; level unchanged.
- abort: highest priority in every non-IDLE state. Go to IDLE next edge; no pulses; led_on, collecting and busy drop the following cycle; level retained.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- All outputs are registered or decoded directly from the state register; no combinational path from input to output.

Test Plan:
1. Assert rst_n=0 mid-operation -> all outputs 0 immediately, level=0; after release, lfsr restarts at 16'hACE1.
2. Reset, start -> level=1; pattern=16'hE270; led_on=1 with led_bit=0 for cycles k+2..k+5; gap 2 cycles; collecting=1. Enter btn 0 -> round_pass pulse, level=2, then a new show starts.
3. Continue to level 2 (pattern 16'h7138, shown bits 0,0). Enter 1,0 -> round_fail and game_over pulse together; state IDLE; level stays 2; busy=0.
4. Level 1, no btn_valid for 32 cycles in COLLECT -> round_fail and game_over on timeout; btn_valid pulsed during SHOW_ON is ignored (received stays 0).
5. abort during the 2nd SHOW_ON cycle -> led_on=0 and busy=0 the next cycle; no round_pass or round_fail; a subsequent start gives level=1 and the next LFSR value 16'h389C.
6. MAX_LEN=2: enter correct bits for levels 1 and 2 -> final PASS asserts round_pass and game_over in the same cycle; level=2; state IDLE.
